// File: rtl/mig_sweep_pkg.sv
// Shared types and constants for the majority-network truth-table sweeper.
package mig_sweep_pkg;

   localparam int MAX_NODES = 8;
   localparam int SEL_W     = 4;
   localparam int TT_W      = 128;
   localparam int VEC_W     = 7;

   // Operand selector encoding: primary inputs, constant zero, then node results.
   localparam logic [SEL_W-1:0] SEL_X0     = 4'd0;
   localparam logic [SEL_W-1:0] SEL_X1     = 4'd1;
   localparam logic [SEL_W-1:0] SEL_X2     = 4'd2;
   localparam logic [SEL_W-1:0] SEL_X3     = 4'd3;
   localparam logic [SEL_W-1:0] SEL_X4     = 4'd4;
   localparam logic [SEL_W-1:0] SEL_X5     = 4'd5;
   localparam logic [SEL_W-1:0] SEL_X6     = 4'd6;
   localparam logic [SEL_W-1:0] SEL_CONST0 = 4'd7;
   localparam logic [SEL_W-1:0] SEL_W0     = 4'd8;

   typedef struct packed {
      logic             inv;
      logic [SEL_W-1:0] sel;
   } operand_t;

   // 15-bit descriptor: {inv_a, sel_a, inv_b, sel_b, inv_c, sel_c}
   typedef struct packed {
      operand_t a;
      operand_t b;
      operand_t c;
   } node_desc_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVAL  = 2'd1,
      ST_STORE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Node k may only reference inputs, the constant, or nodes strictly before it.
   function automatic logic desc_refs_ok(input node_desc_t d, input logic [2:0] k);
      logic [4:0] lim;
      lim = 5'd8 + {2'b00, k};
      return ({1'b0, d.a.sel} < lim) && ({1'b0, d.b.sel} < lim) && ({1'b0, d.c.sel} < lim);
   endfunction

endpackage

// File: rtl/maj3_unit.sv
// Shared three-input majority gate with per-operand inversion.
module maj3_unit (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic inv_a,
   input  logic inv_b,
   input  logic inv_c,
   output logic maj
);

   logic a_s;
   logic b_s;
   logic c_s;

   assign a_s = a ^ inv_a;
   assign b_s = b ^ inv_b;
   assign c_s = c ^ inv_c;
   assign maj = (a_s & b_s) | (a_s & c_s) | (b_s & c_s);

endmodule

// File: rtl/mig_truth_sweeper.sv
// Time-multiplexed evaluator producing the 128-entry truth table of a MAJ3 network.
module mig_truth_sweeper
   import mig_sweep_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_addr,
   input  logic [14:0]       cfg_data,
   input  logic [3:0]        num_nodes,
   input  logic [3:0]        out_sel,
   input  logic              out_inv,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [TT_W-1:0]   tt
);

   state_t                 state_q, state_d;
   logic [VEC_W-1:0]       vec_q, vec_d;
   logic [2:0]             n_q, n_d;
   logic [3:0]             nn_q, nn_d;
   logic [SEL_W-1:0]       osel_q, osel_d;
   logic                   oinv_q, oinv_d;
   node_desc_t             desc_q [MAX_NODES];
   node_desc_t             desc_d [MAX_NODES];
   logic [MAX_NODES-1:0]   w_q, w_d;
   logic [TT_W-1:0]        tt_q, tt_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;

   node_desc_t             cur_desc_s;
   logic                   op_a_s, op_b_s, op_c_s;
   logic                   maj_s;
   logic                   out_val_s;
   logic                   wr_en_s;
   logic                   cfg_ok_s;

   // Value of a selector for the current vector; node results come from registered w.
   function automatic logic operand_value(input logic [SEL_W-1:0] sel,
                                          input logic [VEC_W-1:0] vec,
                                          input logic [MAX_NODES-1:0] w);
      logic v;
      if (sel < SEL_CONST0) begin
         v = vec[sel[2:0]];
      end else if (sel < SEL_W0) begin
         v = 1'b0;
      end else begin
         v = w[sel[2:0]];
      end
      return v;
   endfunction

   // Operand selection for the node being evaluated and for the function output.
   always_comb begin
      cur_desc_s = desc_q[n_q];
      op_a_s     = operand_value(cur_desc_s.a.sel, vec_q, w_q);
      op_b_s     = operand_value(cur_desc_s.b.sel, vec_q, w_q);
      op_c_s     = operand_value(cur_desc_s.c.sel, vec_q, w_q);
      out_val_s  = operand_value(osel_q, vec_q, w_q);
   end

   maj3_unit u_maj (
      .a     (op_a_s),
      .b     (op_b_s),
      .c     (op_c_s),
      .inv_a (cur_desc_s.a.inv),
      .inv_b (cur_desc_s.b.inv),
      .inv_c (cur_desc_s.c.inv),
      .maj   (maj_s)
   );

   // Descriptor write port; the merged view feeds the start check so a same-cycle write counts.
   always_comb begin
      wr_en_s = cfg_we && (state_q != ST_EVAL) && (state_q != ST_STORE);
      for (int k = 0; k < MAX_NODES; k++) begin
         desc_d[k] = (wr_en_s && (cfg_addr == 3'(k))) ? node_desc_t'(cfg_data) : desc_q[k];
      end
   end

   // Configuration legality check evaluated against the live start inputs.
   always_comb begin
      cfg_ok_s = (num_nodes != 4'd0) && (num_nodes <= 4'd8);
      for (int k = 0; k < MAX_NODES; k++) begin
         if (4'(k) < num_nodes) begin
            cfg_ok_s = cfg_ok_s && desc_refs_ok(desc_d[k], 3'(k));
         end else begin
            cfg_ok_s = cfg_ok_s;
         end
      end
      cfg_ok_s = cfg_ok_s && ({1'b0, out_sel} < (5'd8 + {1'b0, num_nodes}));
   end

   // Sweep controller next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      n_d     = n_q;
      nn_d    = nn_q;
      osel_d  = osel_q;
      oinv_d  = oinv_q;
      w_d     = w_q;
      tt_d    = tt_q;
      error_d = error_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (cfg_ok_s) begin
                  error_d = 1'b0;
                  tt_d    = '0;
                  vec_d   = 7'd0;
                  n_d     = 3'd0;
                  nn_d    = num_nodes;
                  osel_d  = out_sel;
                  oinv_d  = out_inv;
                  state_d = ST_EVAL;
               end else begin
                  error_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EVAL: begin
            w_d[n_q] = maj_s;
            if ({1'b0, n_q} == (nn_q - 4'd1)) begin
               state_d = ST_STORE;
            end else begin
               n_d = n_q + 3'd1;
            end
         end
         ST_STORE: begin
            tt_d[vec_q] = out_val_s ^ oinv_q;
            if (vec_q == 7'd127) begin
               state_d = ST_DONE;
            end else begin
               vec_d   = vec_q + 7'd1;
               n_d     = 3'd0;
               state_d = ST_EVAL;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_EVAL) || (state_d == ST_STORE);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         vec_q   <= 7'd0;
         n_q     <= 3'd0;
         nn_q    <= 4'd0;
         osel_q  <= 4'd0;
         oinv_q  <= 1'b0;
         w_q     <= '0;
         tt_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         for (int k = 0; k < MAX_NODES; k++) begin
            desc_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         n_q     <= n_d;
         nn_q    <= nn_d;
         osel_q  <= osel_d;
         oinv_q  <= oinv_d;
         w_q     <= w_d;
         tt_q    <= tt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         for (int k = 0; k < MAX_NODES; k++) begin
            desc_q[k] <= desc_d[k];
         end
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign error = error_q;
   assign tt    = tt_q;

endmodule

// File: doc/mig_truth_sweeper.md
Name: mig_truth_sweeper

Overview:
Sequential evaluator that computes the full 128-entry truth table of a 7-input function described as a majority-gate network of up to 8 MAJ3 nodes. A single shared MAJ3 unit is time-multiplexed: one node per cycle, all 2^7 input vectors swept in order. It feeds the classification flow: software programs a candidate network, pulses start and reads back the truth table for NPN/class comparison.

Parameters:
MAX_NODES, 8, node-descriptor slots; fixed by the 3-bit cfg_addr.
SEL_W, 4, operand selector width.
TT_W, 128, truth-table width (2^7); not overridable.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
cfg_we  in  1  write node descriptor; ignored while busy
cfg_addr  in  3  node index 0..7
cfg_data  in  15  {inv_a, sel_a[3:0], inv_b, sel_b[3:0], inv_c, sel_c[3:0]}
num_nodes  in  4  node count 1..8; sampled when start is accepted
out_sel  in  4  selector of the function output; sampled at start
out_inv  in  1  output inversion; sampled at start
start  in  1  begin sweep; honoured only in IDLE
busy  out  1  sweep in progress
done  out  1  one-cycle completion pulse
error  out  1  sticky configuration error
tt  out  128  truth table; bit v = f(x6..x0 = v[6:0]), x0 = v[0]

Behaviour:
- Selector encoding: 0..6 = x0..x6 (bits of the current vector), 7 = const0, 8..15 = node result w0..w7. Inversion bit XORs the operand before the MAJ.
- Node k computes MAJ(a,b,c) = ab|ac|bc. It may reference only x, const, or w0..w(k-1).
- Reset: busy=0, done=0, error=0, tt=0, every descriptor=0, node registers=0, FSM in IDLE. Reset mid-sweep aborts; state is IDLE and tt=0 on the next cycle.
- FSM states: IDLE, EVAL, STORE, DONE.
- IDLE: on start, check the latched configuration.
  - Invalid: num_nodes==0 or >8; any node k<num_nodes with a selector >= 8+k; out_sel >= 8+num_nodes. Result: error<=1, stay IDLE, tt unchanged.
  - Valid: error<=0, tt<=0, vec<=0, n<=0, latch num_nodes/out_sel/out_inv, go to EVAL.
- EVAL: one cycle per node. w[n] <= MAJ of the selected, optionally inverted operands. Operands read already-registered w values. When n==num_nodes-1, go to STORE; else n++.
- STORE: tt[vec] <= value(out_sel) XOR out_inv. If vec==127, go to DONE; else vec++, n<=0, go to EVAL.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in EVAL and STORE only.
- Latency: start accepted at edge t; busy rises at t+1; done is high in the cycle after t + 128*(num_nodes+1).
- tt holds its value until the next accepted start or rst.
- start while busy or in DONE: ignored, no error.
- cfg_we while busy: ignored. cfg_we and start in the same IDLE cycle: the write lands first and the check uses the new descriptor.
- vec is 7 bits; it never wraps during a sweep because the terminal count is detected at 127.

Decomposition:
- Package mig_sweep_pkg holds:
  - selector constants (SEL_X0..SEL_X6, SEL_CONST0, SEL_W0);
  - the packed node_desc_t operand/descriptor struct;
  - the state enum;
  - TT_W and MAX_NODES.
- One sub-module, maj3_unit: three operands plus three inversion bits in, MAJ out; purely combinational. The controller, selector muxes, descriptor RAM and tt register stay in the top.

Test Plan:
- Node0 = MAJ(x0,x1,x2), num_nodes=1, out_sel=8, out_inv=0 -> done 256 cycles after busy rises; tt[3]=1, tt[1]=0, tt[7]=1, tt[4]=0; tt bit v = maj(v[0],v[1],v[2]) for all v.
- Node0 = MAJ(x0, ~const0, x1) (OR) with out_inv=1 -> tt[v] = ~(v[0]|v[1]); tt[0]=1, tt[1]=0.
- num_nodes=0 or 9 -> error=1, busy stays 0, tt unchanged. Then a valid start -> error clears.
- Node1 sel_a=10 (w2, forward reference), num_nodes=2 -> error=1, no sweep.
- Three-node chain w0=MAJ(x0,x3,x4), w1=MAJ(x1,x2,w0), w2=MAJ(x5,x6,w1), num_nodes=3 -> done after 512 cycles; tt matches a software model.
- Robustness:
  - start and cfg_we pulsed mid-sweep -> no effect on tt or the descriptors;
  - rst asserted at cycle 100 -> busy=0, tt=0 next cycle;
  - a new start afterwards completes normally.
